// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX serializer and future RX path.
// UART_TX_PARITY_EN adds the parity state to tx_state_t.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_DIV_WIDTH  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period counter: latches the divisor on load and flags the last cycle of each bit.
// Counts 0..div_q while enabled; shared between the TX and RX paths.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = UART_DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 bit_end_o
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 bit_end;

  always_comb begin
    bit_end = en_i && (cnt_q == div_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      div_q <= div_i;
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= bit_end ? '0 : cnt_q + DIV_WIDTH'(1);
    end
  end

  assign bit_end_o = bit_end;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts out start/data/stop frames.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DIV_WIDTH  = UART_DIV_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  tx_en_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  stop2_i,
  input  logic                  parity_odd_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rden_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  tx_done_o
);

  localparam int unsigned         BitCntW = $clog2(DATA_WIDTH);
  localparam logic [BitCntW-1:0]  LastBit = BitCntW'(DATA_WIDTH - 1);

  tx_state_t             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BitCntW-1:0]    bit_cnt_q;
  logic                  stop_cnt_q;
  logic                  stop2_q;
  logic                  tx_q;
  logic                  busy_q;

  logic                  pop;
  logic                  fetch;
  logic                  baud_run;
  logic                  bit_end;
  logic                  last_stop;

`ifdef UART_TX_PARITY_EN
  logic                  parity_odd_q;
  logic                  par_q;
`else
  logic                  unused_parity_odd;
  assign unused_parity_odd = parity_odd_i;
`endif

  always_comb begin
    pop       = (state_q == StIdle) && tx_en_i && !fifo_empty_i;
    fetch     = (state_q == StFetch);
    baud_run  = (state_q != StIdle) && (state_q != StFetch);
    last_stop = (stop_cnt_q == stop2_q);
  end

  uart_baud_cnt #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_cnt (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .load_i    (pop),
    .clear_i   (fetch),
    .en_i      (baud_run),
    .div_i     (baud_div_i),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      stop2_q      <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_odd_q <= 1'b0;
      par_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            stop2_q      <= stop2_i;
`ifdef UART_TX_PARITY_EN
            parity_odd_q <= parity_odd_i;
`endif
            busy_q       <= 1'b1;
            state_q      <= StFetch;
          end
        end
        StFetch: begin
          shift_q    <= fifo_rdata_i;
          bit_cnt_q  <= '0;
          stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
          par_q      <= (^fifo_rdata_i) ^ parity_odd_q;
`endif
          // Registered line: drive the start bit so it appears on entry to StStart.
          tx_q       <= 1'b0;
          state_q    <= StStart;
        end
        StStart: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= StParity;
`else
              tx_q    <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
              tx_q      <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          if (bit_end) begin
            if (last_stop) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fifo_rden_o = pop;
  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign tx_done_o   = (state_q == StStop) && bit_end && last_stop;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: per-cycle line log plus hand-computed frame patterns.
// Parity expectations switch on UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tx_en = 1'b0;
  logic [15:0] baud_div = '0;
  logic        stop2 = 1'b0;
  logic        parity_odd = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rdata = '0;
  logic        fifo_rden;
  logic        tx;
  logic        busy;
  logic        tx_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo_q[$];
  logic       tx_log[$];
  int         rden_cyc[$];
  int         done_cyc[$];
  int         rden_cnt = 0;
  int         done_cnt = 0;
  int         busy_cnt = 0;
  int         txlow_cnt = 0;
  int         viol_cnt = 0;

  uart_tx_serializer dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .tx_en_i      (tx_en),
    .baud_div_i   (baud_div),
    .stop2_i      (stop2),
    .parity_odd_i (parity_odd),
    .fifo_empty_i (fifo_empty),
    .fifo_rdata_i (fifo_rdata),
    .fifo_rden_o  (fifo_rden),
    .tx_o         (tx),
    .busy_o       (busy),
    .tx_done_o    (tx_done)
  );

  always #5 clk = ~clk;

  // FIFO model: read data valid the cycle after the pop strobe.
  always @(posedge clk) begin
    if (fifo_rden && fifo_q.size() != 0) fifo_rdata <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor samples on the falling edge; log index == cycle number.
  always @(negedge clk) begin
    if (fifo_rden) begin
      rden_cyc.push_back(tx_log.size());
      rden_cnt <= rden_cnt + 1;
    end
    if (tx_done) begin
      done_cyc.push_back(tx_log.size());
      done_cnt <= done_cnt + 1;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (!tx) txlow_cnt <= txlow_cnt + 1;
    if (fifo_rden && fifo_empty) viol_cnt <= viol_cnt + 1;
    tx_log.push_back(tx);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int start, input int div, input int nbits,
                             input logic [15:0] exp);
    logic [15:0] got;
    int idx;
    got = '0;
    for (int k = 0; k < nbits; k++) begin
      idx = start + (div + 1) * k + div / 2;
      got[k] = (idx >= 0 && idx < tx_log.size()) ? tx_log[idx] : 1'bx;
    end
    check_eq(tag, 32'(got), 32'(exp));
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_rden(input int target, input int budget);
    int n = 0;
    while (rden_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, db, bb, lb, s0, s1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rden", 32'(fifo_rden), 32'd0);
    check_eq("rst_done", 32'(tx_done), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cycles(2);

    // 0xA5, div 3, one stop, even parity if present
    baud_div = 16'd3; stop2 = 1'b0; parity_odd = 1'b0; tx_en = 1'b1;
    rb = rden_cnt; db = done_cnt; bb = busy_cnt;
    fifo_q.push_back(8'hA5);
    wait_done(db + 1, 300);
    cycles(4);
    check_eq("a5_done", done_cnt - db, 1);
    check_eq("a5_pops", rden_cnt - rb, 1);
    s0 = rden_cyc[rb] + 2;
    check_eq("a5_edge", 32'({tx_log[s0-1], tx_log[s0]}), 32'b10);
    check_frame("a5_bits", s0, 3, 10 + P, (P == 1) ? 16'h054A : 16'h034A);
    check_eq("a5_len", done_cyc[db] - s0 + 1, 40 + 4 * P);
    check_eq("a5_busy", busy_cnt - bb, 41 + 4 * P);

`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b1;
    rb = rden_cnt; db = done_cnt;
    fifo_q.push_back(8'hA5);
    wait_done(db + 1, 300);
    cycles(4);
    check_eq("a5odd_done", done_cnt - db, 1);
    s0 = rden_cyc[rb] + 2;
    check_frame("a5odd_bits", s0, 3, 11, 16'h074A);
    check_eq("a5odd_len", done_cyc[db] - s0 + 1, 44);
    parity_odd = 1'b0;
`endif

    // Back-to-back 0x01, 0x80 at div 0 with two stop bits
    tx_en = 1'b0; baud_div = 16'd0; stop2 = 1'b1;
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h80);
    cycles(2);
    rb = rden_cnt; db = done_cnt;
    tx_en = 1'b1;
    wait_done(db + 2, 300);
    cycles(4);
    check_eq("b2b_pops", rden_cnt - rb, 2);
    check_eq("b2b_done", done_cnt - db, 2);
    s0 = rden_cyc[rb] + 2;
    s1 = rden_cyc[rb + 1] + 2;
    check_frame("b2b_bits0", s0, 0, 11 + P, (P == 1) ? 16'h0E02 : 16'h0602);
    check_frame("b2b_bits1", s1, 0, 11 + P, (P == 1) ? 16'h0F00 : 16'h0700);
    check_eq("b2b_len0", done_cyc[db] - s0 + 1, 11 + P);
    check_eq("b2b_len1", done_cyc[db + 1] - s1 + 1, 11 + P);
    check_eq("b2b_gap", s1 - done_cyc[db] - 1, 2);
    check_eq("b2b_gap_high", 32'({tx_log[done_cyc[db]+1], tx_log[done_cyc[db]+2]}), 32'b11);

    // Idle: enabled but empty, then non-empty but disabled
    stop2 = 1'b0; baud_div = 16'd3;
    rb = rden_cnt; bb = busy_cnt; lb = txlow_cnt;
    cycles(100);
    check_eq("empty_rden", rden_cnt - rb, 0);
    check_eq("empty_busy", busy_cnt - bb, 0);
    check_eq("empty_txlow", txlow_cnt - lb, 0);
    tx_en = 1'b0;
    fifo_q.push_back(8'h55);
    rb = rden_cnt; bb = busy_cnt; lb = txlow_cnt;
    cycles(100);
    check_eq("dis_rden", rden_cnt - rb, 0);
    check_eq("dis_busy", busy_cnt - bb, 0);
    check_eq("dis_txlow", txlow_cnt - lb, 0);
    fifo_q.delete();
    cycles(2);

    // Reset during data bit 3 of 0xA5
    tx_en = 1'b1;
    rb = rden_cnt;
    fifo_q.push_back(8'hA5);
    wait_rden(rb + 1, 50);
    repeat (18) @(posedge clk);
    @(negedge clk);
    check_eq("rstmid_pre_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_eq("rstmid_tx", 32'(tx), 32'd1);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    lb = txlow_cnt; db = done_cnt;
    cycles(20);
    check_eq("rstmid_quiet_rden", rden_cnt - rb, 1);
    check_eq("rstmid_quiet_tx", txlow_cnt - lb, 0);
    check_eq("rstmid_no_done", done_cnt - db, 0);
    fifo_q.push_back(8'h3C);
    wait_done(db + 1, 300);
    cycles(4);
    check_eq("rstmid_pops", rden_cnt - rb, 2);
    s0 = rden_cyc[rb + 1] + 2;
    check_frame("rstmid_bits", s0, 3, 10 + P, (P == 1) ? 16'h0478 : 16'h0278);

    // Divisor change 3 -> 7 during the first frame
    tx_en = 1'b0; baud_div = 16'd3;
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'hC3);
    cycles(2);
    rb = rden_cnt; db = done_cnt;
    tx_en = 1'b1;
    wait_rden(rb + 1, 50);
    baud_div = 16'd7;
    wait_done(db + 2, 600);
    cycles(4);
    check_eq("div_done", done_cnt - db, 2);
    s0 = rden_cyc[rb] + 2;
    s1 = rden_cyc[rb + 1] + 2;
    check_frame("div_bits0", s0, 3, 10 + P, (P == 1) ? 16'h04B4 : 16'h02B4);
    check_frame("div_bits1", s1, 7, 10 + P, (P == 1) ? 16'h0586 : 16'h0386);
    check_eq("div_len0", done_cyc[db] - s0 + 1, 40 + 4 * P);
    check_eq("div_len1", done_cyc[db + 1] - s1 + 1, 80 + 8 * P);

    check_eq("rden_while_empty", viol_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
